// File: rtl/v_pkg.sv
// rtl/v_pkg.sv - shared types, unit indices and LMUL helpers for the vector issue path
package v_pkg;

    // Widest unit index an entry can carry; tops with fewer units use the low bits.
    localparam int V_FU_MAX_W = 4;

    localparam int FU_LANES = 0;
    localparam int FU_RED   = 1;
    localparam int FU_SLDU  = 2;
    localparam int FU_LSU   = 3;

    localparam logic [2:0] LMUL_1 = 3'b000;
    localparam logic [2:0] LMUL_2 = 3'b001;
    localparam logic [2:0] LMUL_4 = 3'b010;

    typedef struct packed {
        logic [31:0]           instr;
        logic [V_FU_MAX_W-1:0] fu;
        logic                  rd_vs1;
        logic                  rd_vs2;
        logic                  wr_vd;
        logic                  is_cfg;
    } v_issue_entry_t;

    // Register-group shift for an LMUL encoding; reserved encodings act as LMUL=1.
    function automatic logic [1:0] lmul_shift(input logic [2:0] vlmul);
        case (vlmul)
            LMUL_2:  return 2'd1;
            LMUL_4:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Two registers overlap when they fall in the same LMUL-aligned group.
    function automatic logic reg_group_eq(input logic [4:0] a, input logic [4:0] b,
                                          input logic [1:0] shift);
        return (a >> shift) == (b >> shift);
    endfunction

endpackage

// File: rtl/v_sync_fifo.sv
// rtl/v_sync_fifo.sv - synchronous circular-buffer fifo with occupancy count
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   wr_valid/wr_ready    write handshake; a push needs a free slot this cycle
//   wr_data              word to push
//   rd_valid             fifo non-empty; rd_data shows the head
//   rd_en                pop the head (ignored when empty)
//   count                current occupancy
module v_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // A full fifo refuses writes even if the head leaves in the same cycle.
    assign wr_ready = (count != CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_en & rd_valid;
    assign rd_data  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/carrd_issue_sb.sv
// rtl/carrd_issue_sb.sv - in-order vector issue queue with per-unit scoreboard
//
// Ports:
//   clk, nrst                    clock, asynchronous active-low reset
//   in_valid/in_ready            instruction hand-off from the base processor
//   in_instr, in_fu              raw instruction and pre-decoded target unit
//   in_rd_vs1/in_rd_vs2/in_wr_vd operand-usage flags
//   in_is_cfg                    vsetvl-class instruction (drains all units)
//   vlmul                        current LMUL encoding
//   issue_valid/instr/fu         one-cycle issue strobe for the queue head
//   fu_done                      per-unit completion pulses
//   fu_busy                      scoreboard busy bits
//   idle                         queue empty and no unit busy
//   err_spurious                 sticky: completion seen on an idle unit
module carrd_issue_sb
    import v_pkg::*;
#(
    parameter  int QDEPTH = 4,
    parameter  int NUM_FU = 4,
    localparam int FUW    = $clog2(NUM_FU),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [FUW-1:0]    in_fu,
    input  logic              in_rd_vs1,
    input  logic              in_rd_vs2,
    input  logic              in_wr_vd,
    input  logic              in_is_cfg,
    input  logic [2:0]        vlmul,
    output logic              issue_valid,
    output logic [31:0]       issue_instr,
    output logic [FUW-1:0]    issue_fu,
    input  logic [NUM_FU-1:0] fu_done,
    output logic [NUM_FU-1:0] fu_busy,
    output logic              idle,
    output logic              err_spurious
);

    localparam int EW = $bits(v_issue_entry_t);

    v_issue_entry_t in_entry;
    v_issue_entry_t head;
    logic           head_valid;
    logic [CW-1:0]  q_count;

    logic [NUM_FU-1:0] busy;
    logic [NUM_FU-1:0] sb_wr;
    logic [4:0]        sb_vd [NUM_FU];

    logic [FUW-1:0] head_fu;
    logic [4:0]     head_vd;
    logic [4:0]     head_vs1;
    logic [4:0]     head_vs2;
    logic [1:0]     shift;
    logic           raw_hit;
    logic           waw_hit;
    logic           struct_hit;
    logic           cfg_hit;
    logic           can_issue;
    logic           unused_fu_bits;

    always_comb begin
        in_entry        = '0;
        in_entry.instr  = in_instr;
        in_entry.fu     = V_FU_MAX_W'(in_fu);
        in_entry.rd_vs1 = in_rd_vs1;
        in_entry.rd_vs2 = in_rd_vs2;
        in_entry.wr_vd  = in_wr_vd;
        in_entry.is_cfg = in_is_cfg;
    end

    v_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_data  (in_entry),
        .rd_valid (head_valid),
        .rd_en    (can_issue),
        .rd_data  (head),
        .count    (q_count)
    );

    assign head_fu        = head.fu[FUW-1:0];
    assign head_vd        = head.instr[11:7];
    assign head_vs1       = head.instr[19:15];
    assign head_vs2       = head.instr[24:20];
    assign unused_fu_bits = ^head.fu;

    // Hazards look only at registered busy state; a completion this cycle
    // frees its dependants from the next cycle on.
    always_comb begin
        shift   = lmul_shift(vlmul);
        raw_hit = 1'b0;
        waw_hit = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (busy[i] && sb_wr[i]) begin
                if (head.rd_vs1 && reg_group_eq(sb_vd[i], head_vs1, shift)) raw_hit = 1'b1;
                if (head.rd_vs2 && reg_group_eq(sb_vd[i], head_vs2, shift)) raw_hit = 1'b1;
                if (head.wr_vd  && reg_group_eq(sb_vd[i], head_vd,  shift)) waw_hit = 1'b1;
            end
        end
    end

    assign struct_hit = busy[head_fu];
    assign cfg_hit    = head.is_cfg & (|busy);
    assign can_issue  = head_valid & ~struct_hit & ~raw_hit & ~waw_hit & ~cfg_hit;

    assign issue_valid = can_issue;
    assign issue_instr = head_valid ? head.instr : 32'd0;
    assign issue_fu    = head_valid ? head_fu : '0;
    assign fu_busy     = busy;
    assign idle        = ~head_valid & ~(|busy);

    // Config instructions are a strobe only; they never occupy a unit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy         <= '0;
            sb_wr        <= '0;
            err_spurious <= 1'b0;
            for (int i = 0; i < NUM_FU; i++) sb_vd[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (can_issue && !head.is_cfg && (head_fu == FUW'(i))) begin
                    busy[i]  <= 1'b1;
                    sb_vd[i] <= head_vd;
                    sb_wr[i] <= head.wr_vd;
                end else if (fu_done[i]) begin
                    busy[i]  <= 1'b0;
                end
            end
            if (|(fu_done & ~busy)) err_spurious <= 1'b1;
        end
    end

endmodule
